cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 151 +++++++++++++++
 tb/tb_cycle_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
//   Machine-cycle / timing-phase sequencer for a simple processor control unit.
//   A three-state control FSM (IDLE, RUN, HALTED) steps a one-hot phase
//   vector T through up to NPHASE phases per machine cycle, and advances the
//   machine cycle M through FETCH -> (DEFER) -> EXEC. The end of each EXEC
//   cycle is an instruction boundary: the instruction counter advances and
//   the stop, single-step and halt decisions are taken there.
//
// Parameters
//   NPHASE     phases per full-length machine cycle (2..8)
//
// Ports
//   clk        system clock, rising edge
//   CLEAR      asynchronous active-high reset
//   RUN        start pulse, honoured only in IDLE
//   STOP       stop request pulse, acted on at the next instruction boundary
//   STEP       level, return to IDLE after every instruction
//   INDIRECT   decoder flag, sampled at the end of FETCH
//   HALT_INSN  decoder flag, sampled at the end of EXEC
//   CYC_END    decoder early end of the current machine cycle
//   T          one-hot phase, zero when not running
//   M          machine cycle: 00 FETCH, 01 DEFER, 10 EXEC
//   running    high in RUN
//   halted     high in HALTED
//   insn_done  one-clock pulse after each completed instruction
//   icount     completed-instruction count (wraps at 16 bits)
module cycle_sequencer #(
  parameter int NPHASE = 8
) (
  input  logic        clk,
  input  logic        CLEAR,
  input  logic        RUN,
  input  logic        STOP,
  input  logic        STEP,
  input  logic        INDIRECT,
  input  logic        HALT_INSN,
  input  logic        CYC_END,
  output logic [7:0]  T,
  output logic [1:0]  M,
  output logic        running,
  output logic        halted,
  output logic        insn_done,
  output logic [15:0] icount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  localparam logic [1:0] M_FETCH = 2'b00;
  localparam logic [1:0] M_DEFER = 2'b01;
  localparam logic [1:0] M_EXEC  = 2'b10;

  state_t      state_q, state_d;
  logic        stop_pending_q, stop_pending_d;
  logic [7:0]  t_d;
  logic [1:0]  m_d;
  logic        running_d, halted_d, insn_done_d;
  logic [15:0] icount_d;

  // A STOP arriving on the boundary edge itself still counts.
  logic stop_seen;
  logic cyc_last;

  assign stop_seen = stop_pending_q | STOP;
  assign cyc_last  = T[NPHASE-1] | CYC_END;

  always_comb begin
    state_d        = state_q;
    stop_pending_d = stop_pending_q;
    t_d            = T;
    m_d            = M;
    running_d      = running;
    halted_d       = halted;
    insn_done_d    = 1'b0;
    icount_d       = icount;

    unique case (state_q)
      S_IDLE: begin
        // A STOP on the same edge as RUN is not remembered: run starts cleanly.
        if (RUN) begin
          state_d   = S_RUN;
          t_d       = 8'h01;
          m_d       = M_FETCH;
          running_d = 1'b1;
        end
      end

      S_RUN: begin
        stop_pending_d = stop_seen;
        if (!cyc_last) begin
          t_d = T << 1;
        end else begin
          t_d = 8'h01;
          unique case (M)
            M_FETCH: m_d = INDIRECT ? M_DEFER : M_EXEC;
            M_DEFER: m_d = M_EXEC;
            default: begin
              // Instruction boundary: the only place execution may stop.
              m_d         = M_FETCH;
              icount_d    = icount + 16'd1;
              insn_done_d = 1'b1;
              if (HALT_INSN) begin
                state_d        = S_HALTED;
                t_d            = 8'h00;
                running_d      = 1'b0;
                halted_d       = 1'b1;
                stop_pending_d = 1'b0;
              end else if (stop_seen || STEP) begin
                state_d        = S_IDLE;
                t_d            = 8'h00;
                running_d      = 1'b0;
                stop_pending_d = 1'b0;
              end
            end
          endcase
        end
      end

      default: begin
        // HALTED is sticky; only CLEAR leaves it.
        state_d = S_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge CLEAR) begin
    if (CLEAR) begin
      state_q        <= S_IDLE;
      stop_pending_q <= 1'b0;
      T              <= 8'h00;
      M              <= M_FETCH;
      running        <= 1'b0;
      halted         <= 1'b0;
      insn_done      <= 1'b0;
      icount         <= 16'h0000;
    end else begin
      state_q        <= state_d;
      stop_pending_q <= stop_pending_d;
      T              <= t_d;
      M              <= m_d;
      running        <= running_d;
      halted         <= halted_d;
      insn_done      <= insn_done_d;
      icount         <= icount_d;
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;

  logic        clk;
  logic        CLEAR, RUN, STOP, STEP, INDIRECT, HALT_INSN, CYC_END;
  logic [7:0]  T;
  logic [1:0]  M;
  logic        running, halted, insn_done;
  logic [15:0] icount;

  int total;
  int bad;

  cycle_sequencer #(.NPHASE(8)) dut (
    .clk       (clk),
    .CLEAR     (CLEAR),
    .RUN       (RUN),
    .STOP      (STOP),
    .STEP      (STEP),
    .INDIRECT  (INDIRECT),
    .HALT_INSN (HALT_INSN),
    .CYC_END   (CYC_END),
    .T         (T),
    .M         (M),
    .running   (running),
    .halted    (halted),
    .insn_done (insn_done),
    .icount    (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] et, input logic [1:0] em,
                           input logic er, input logic eh);
    chk({tag, ".T"}, {24'h0, T}, {24'h0, et});
    chk({tag, ".M"}, {30'h0, M}, {30'h0, em});
    chk({tag, ".running"}, {31'h0, running}, {31'h0, er});
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, eh});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    CLEAR = 1'b1; RUN = 1'b0; STOP = 1'b0; STEP = 1'b0;
    INDIRECT = 1'b0; HALT_INSN = 1'b0; CYC_END = 1'b0;
    #1;
    chk_state("reset", 8'h00, 2'b00, 1'b0, 1'b0);
    chk("reset.insn_done", {31'h0, insn_done}, 32'h0);
    chk("reset.icount", {16'h0, icount}, 32'h0);
    tick(); tick();
    CLEAR = 1'b0;
    tick(); tick(); tick();
    chk_state("idle_wait", 8'h00, 2'b00, 1'b0, 1'b0);

    // Full-length instruction: FETCH 8 phases, EXEC 8 phases.
    RUN = 1'b1; tick(); RUN = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_state($sformatf("i1.fetch%0d", k), 8'h01 << k, 2'b00, 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk_state($sformatf("i1.exec%0d", k), 8'h01 << k, 2'b10, 1'b1, 1'b0);
      chk($sformatf("i1.exec%0d.done", k), {31'h0, insn_done}, 32'h0);
      tick();
    end
    chk_state("i1.end", 8'h01, 2'b00, 1'b1, 1'b0);
    chk("i1.insn_done", {31'h0, insn_done}, 32'h1);
    chk("i1.icount", {16'h0, icount}, 32'd1);

    // Indirect instruction: FETCH, DEFER, EXEC = 24 clocks.
    INDIRECT = 1'b1;
    repeat (8) tick();
    chk_state("i2.defer", 8'h01, 2'b01, 1'b1, 1'b0);
    chk("i2.defer.done", {31'h0, insn_done}, 32'h0);
    INDIRECT = 1'b0;
    repeat (8) tick();
    chk_state("i2.exec", 8'h01, 2'b10, 1'b1, 1'b0);
    chk("i2.exec.icount", {16'h0, icount}, 32'd1);
    repeat (8) tick();
    chk_state("i2.end", 8'h01, 2'b00, 1'b1, 1'b0);
    chk("i2.insn_done", {31'h0, insn_done}, 32'h1);
    chk("i2.icount", {16'h0, icount}, 32'd2);

    // STOP mid-FETCH plus CYC_END at T=04: 3-clock FETCH, instruction completes.
    tick();
    chk_state("i3.t02", 8'h02, 2'b00, 1'b1, 1'b0);
    STOP = 1'b1; tick(); STOP = 1'b0;
    chk_state("i3.t04", 8'h04, 2'b00, 1'b1, 1'b0);
    CYC_END = 1'b1; tick(); CYC_END = 1'b0;
    chk_state("i3.exec", 8'h01, 2'b10, 1'b1, 1'b0);
    repeat (7) tick();
    chk_state("i3.exec_last", 8'h80, 2'b10, 1'b1, 1'b0);
    tick();
    chk_state("i3.stopped", 8'h00, 2'b00, 1'b0, 1'b0);
    chk("i3.insn_done", {31'h0, insn_done}, 32'h1);
    chk("i3.icount", {16'h0, icount}, 32'd3);
    tick();
    chk("i3.done_drop", {31'h0, insn_done}, 32'h0);
    chk_state("i3.idle", 8'h00, 2'b00, 1'b0, 1'b0);

    // STOP while idle is ignored; one-phase cycles via CYC_END held high.
    STOP = 1'b1; tick(); STOP = 1'b0;
    CYC_END = 1'b1;
    RUN = 1'b1; tick(); RUN = 1'b0;
    chk_state("i4.fetch", 8'h01, 2'b00, 1'b1, 1'b0);
    RUN = 1'b1; tick(); RUN = 1'b0;
    chk_state("i4.exec", 8'h01, 2'b10, 1'b1, 1'b0);
    tick();
    chk_state("i4.continue", 8'h01, 2'b00, 1'b1, 1'b0);
    chk("i4.icount", {16'h0, icount}, 32'd4);

    // STEP: return to IDLE after each instruction.
    STEP = 1'b1;
    tick(); tick();
    chk_state("step1.idle", 8'h00, 2'b00, 1'b0, 1'b0);
    chk("step1.icount", {16'h0, icount}, 32'd5);
    tick();
    chk_state("step1.hold", 8'h00, 2'b00, 1'b0, 1'b0);
    RUN = 1'b1; tick(); RUN = 1'b0;
    tick(); tick();
    chk_state("step2.idle", 8'h00, 2'b00, 1'b0, 1'b0);
    chk("step2.icount", {16'h0, icount}, 32'd6);
    STEP = 1'b0;

    // RUN and STOP on the same idle edge: no stop pending.
    RUN = 1'b1; STOP = 1'b1; tick(); RUN = 1'b0; STOP = 1'b0;
    tick(); tick();
    chk_state("runstop.continue", 8'h01, 2'b00, 1'b1, 1'b0);
    chk("runstop.icount", {16'h0, icount}, 32'd7);

    // HALT_INSN with STOP pending: HALT wins, HALTED is sticky.
    STOP = 1'b1; tick(); STOP = 1'b0;
    HALT_INSN = 1'b1; tick(); HALT_INSN = 1'b0;
    chk_state("halt", 8'h00, 2'b00, 1'b0, 1'b1);
    chk("halt.icount", {16'h0, icount}, 32'd8);
    chk("halt.insn_done", {31'h0, insn_done}, 32'h1);
    RUN = 1'b1; tick(); RUN = 1'b0;
    tick();
    chk_state("halt.run_ignored", 8'h00, 2'b00, 1'b0, 1'b1);
    CLEAR = 1'b1; #1;
    chk_state("halt.clear", 8'h00, 2'b00, 1'b0, 1'b0);
    chk("halt.clear.icount", {16'h0, icount}, 32'd0);
    CLEAR = 1'b0;
    CYC_END = 1'b0;

    // Asynchronous CLEAR at T=10 mid-EXEC.
    tick();
    RUN = 1'b1; tick(); RUN = 1'b0;
    repeat (12) tick();
    chk_state("clr.before", 8'h10, 2'b10, 1'b1, 1'b0);
    CLEAR = 1'b1; #2;
    chk_state("clr.async", 8'h00, 2'b00, 1'b0, 1'b0);
    chk("clr.icount", {16'h0, icount}, 32'd0);
    chk("clr.insn_done", {31'h0, insn_done}, 32'h0);
    CLEAR = 1'b0;
    tick(); tick();
    chk_state("clr.stay_idle", 8'h00, 2'b00, 1'b0, 1'b0);

    // Counter wrap from a preloaded value.
    force dut.icount = 16'hFFFE;
    #1;
    release dut.icount;
    tick();
    chk("wrap.preload", {16'h0, icount}, 32'h0000FFFE);
    CYC_END = 1'b1;
    RUN = 1'b1; tick(); RUN = 1'b0;
    tick(); tick();
    chk("wrap.ffff", {16'h0, icount}, 32'h0000FFFF);
    tick(); tick();
    chk("wrap.zero", {16'h0, icount}, 32'h00000000);
    chk("wrap.insn_done", {31'h0, insn_done}, 32'h1);
    CYC_END = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
